apb4_mem_slave: RTL
===================

# apb4_mem_slave

Parametrised APB4 completer fronting a single-port word memory, successor to the APB3 slave used behind the dual-port memory.
- Adds byte write strobes (PSTRB), error response (PSLVERR), programmable wait states and a relocatable base address.
- Sits on the APB bus as one completer.
- Memory is internal; contents are not cleared by reset.

## Interface
- ADDR_WIDTH, 32, PADDR width in bits (byte address).
- DATA_WIDTH, 32, bus and word width; legal values 8, 16, 32, 64. BYTES = DATA_WIDTH/8.
- DEPTH, 256, number of words; power of two, at least 2.
- WAIT_STATES, 0, wait cycles inserted in every access phase; 0..15.
- BASE_ADDR, 0, byte address of word 0; aligned to DEPTH*BYTES.
- PCLK  in  1  clock; all state changes on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase marker.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  BYTES  write byte-lane enables; ignored on reads.
- PRDATA  out  DATA_WIDTH  read data; valid only when PREADY=1 and PWRITE=0.
- PREADY  out  1  access phase complete.
- PSLVERR  out  1  error response; qualified by PREADY.

## Operation
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, state=IDLE, wait counter=0.
- FSM states:
  - IDLE: waits for a setup phase.
  - ACCESS: access phase in progress.
- Setup is detected when PSEL=1 and PENABLE=0, in either IDLE or the cycle after a completed ACCESS. On that edge the block:
  - computes off = PADDR - BASE_ADDR, using ADDR_WIDTH-bit unsigned arithmetic;
  - latches err = (PADDR < BASE_ADDR) or (off >= DEPTH*BYTES) or (off mod BYTES != 0);
  - latches idx = off / BYTES, truncated to log2(DEPTH) bits;
  - loads the wait counter with WAIT_STATES;
  - registers PRDATA = err ? 0 : mem[idx] for reads; for writes PRDATA holds its previous value;
  - moves to ACCESS.
- In ACCESS:
  - PREADY = (counter == 0), combinational from registered state only.
  - While the counter is nonzero and PSEL=PENABLE=1, the counter decrements each cycle.
  - The transfer completes on the edge where PSEL=PENABLE=PREADY=1.
- On a write completion with err=0, each byte lane i where PSTRB[i]=1 is written from PWDATA. PSTRB=0 leaves memory unchanged with no error.
- On completion with err=1, memory is untouched, PSLVERR=1 and PRDATA=0.
- PSLVERR is 0 whenever PREADY=0.
- After completion:
  - PSEL=1 and PENABLE=0 is a back-to-back setup and moves straight back to ACCESS.
  - Anything else goes to IDLE.
- Protocol violations:
  - PSEL deasserted in ACCESS before completion aborts to IDLE; no write occurs.
  - PSEL=1 and PENABLE=1 seen in IDLE is ignored, and PREADY stays 0.
  - PADDR, PWRITE, PWDATA and PSTRB changing during ACCESS are not sampled; the latched address and error are used, and write data and strobes are taken at the completion edge.
- Asynchronous reset at any time forces IDLE with all outputs at reset values. An in-flight write is dropped, and memory is unchanged.

## Timing
- Zero wait: setup in cycle T0, PREADY=1 in T1, completion at the end of T1; 2 cycles per transfer.
- N wait states: PREADY=0 for T1..TN, PREADY=1 in T(N+1); 2+N cycles per transfer.
- Back-to-back transfers sustain one transfer per 2+N cycles with no idle cycle.
- Read data is registered at the end of setup, so PRDATA is stable throughout ACCESS.
- A read immediately after a write to the same word returns the new data, because the write commits before the next setup edge.
- PREADY and PSLVERR are glitch-free: they depend only on flops.

## Test plan
Configuration for all scenarios: DATA_WIDTH=32, DEPTH=256, BASE_ADDR=0x1000.
- WAIT_STATES=0; write 0xDEADBEEF to 0x1004 with PSTRB=0xF, then read 0x1004:
  - PREADY is high in the second cycle of each transfer;
  - PRDATA=0xDEADBEEF with PSLVERR=0.
- Partial strobe:
  - write 0x11223344 to 0x1008 with PSTRB=0xF, then write 0xAABBCCDD with PSTRB=0x5;
  - a read of 0x1008 returns 0x11BB33DD.
- Errors, each returning PSLVERR=1 with PREADY:
  - read 0x0FFC returns PRDATA=0;
  - write 0x1400 (off=1024) leaves memory unchanged;
  - write 0x1002 (misaligned) leaves the 0x1000 word unchanged.
- WAIT_STATES=3:
  - a read shows PREADY low for 3 access cycles and high on the 4th;
  - back-to-back write then read of 0x10FC completes in 10 cycles total, with read data equal to the written data.
- Abort and reset:
  - PSEL dropped in the 2nd wait cycle of a write to 0x1010: later read shows the old value.
  - PRESETn pulsed low mid-access (asynchronous, between clock edges): PREADY, PSLVERR and PRDATA go to 0 immediately, the FSM restarts cleanly on the next setup, and prior memory contents are intact.

Source files
------------

// File: rtl/apb4_mem_slave.sv
// APB4 completer in front of a single-port word memory with byte strobes,
// PSLVERR on out-of-range/misaligned accesses and fixed wait states.
module apb4_mem_slave #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH       = 256,
   parameter int                    WAIT_STATES = 0,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int BYTES   = DATA_WIDTH / 8;
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int OFF_LSB = $clog2(BYTES);
   localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH+1)'(DEPTH * BYTES);
   localparam logic [3:0]          CNT_LOAD = 4'(WAIT_STATES);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic                  err_q;
   logic                  wr_q;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] prdata_q;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] off_d;
   logic                  err_d;
   logic [IDX_W-1:0]      idx_d;
   logic                  setup;
   logic                  wr_en;

   // Decode is evaluated every cycle but only captured on a setup edge.
   assign off_d = PADDR - BASE_ADDR;
   assign err_d = (PADDR < BASE_ADDR) || ({1'b0, off_d} >= SPAN) ||
                  ((off_d & ADDR_WIDTH'(BYTES - 1)) != '0);
   assign idx_d = IDX_W'(off_d >> OFF_LSB);
   assign setup = PSEL && !PENABLE;

   assign PREADY  = (state_q == S_ACCESS) && (cnt_q == 4'd0);
   assign PSLVERR = PREADY && err_q;
   assign PRDATA  = prdata_q;
   assign wr_en   = PREADY && PSEL && PENABLE && wr_q && !err_q;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         wr_q     <= 1'b0;
         idx_q    <= '0;
         prdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (setup) begin
                  state_q <= S_ACCESS;
                  cnt_q   <= CNT_LOAD;
                  err_q   <= err_d;
                  wr_q    <= PWRITE;
                  idx_q   <= idx_d;
                  if (err_d)
                     prdata_q <= '0;
                  else if (!PWRITE)
                     prdata_q <= mem[idx_d];
               end
            end
            S_ACCESS: begin
               // Completion returns to IDLE, where a same-cycle setup is caught next edge.
               if (!PSEL)
                  state_q <= S_IDLE;
               else if (PENABLE) begin
                  if (cnt_q != 4'd0)
                     cnt_q <= cnt_q - 4'd1;
                  else
                     state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Memory has no reset; contents survive PRESETn.
   always_ff @(posedge PCLK) begin
      if (wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (PSTRB[b])
               mem[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
         end
      end
   end

endmodule
